// File: rtl/synch_edge_detect_multi.sv
// Multi-channel synchroniser + edge detector with sticky event flags.
// Optional glitch filter compiled in with `define SYNCH_DETECT_FILTER_EN.
module synch_edge_detect_multi #(
  parameter int          N_CH          = 4,
  parameter int          SYNC_STAGES   = 2,
  parameter int          FILTER_CYCLES = 4,
  parameter logic [N_CH-1:0] INIT_LEVEL = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   async_in,
  input  logic [2*N_CH-1:0] edge_sel,
  input  logic [N_CH-1:0]   flag_clr,
  output logic [N_CH-1:0]   level_out,
  output logic [N_CH-1:0]   rise_edge,
  output logic [N_CH-1:0]   fall_edge,
  output logic [N_CH-1:0]   event_pulse,
  output logic [N_CH-1:0]   event_flag,
  output logic              irq
);

  if (N_CH < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad
    $error("synch_edge_detect_multi: illegal parameters");
  end

  logic [N_CH-1:0] sync_r [SYNC_STAGES];
  logic [N_CH-1:0] sync_q;
  logic [N_CH-1:0] level_d;
  logic [N_CH-1:0] flag_r;

  // Synchroniser chain: stage 0 samples the raw asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_r[s] <= INIT_LEVEL;
    end else begin
      sync_r[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_r[s] <= sync_r[s-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

`ifdef SYNCH_DETECT_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] level_r;

  // Filter: accept a new level after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= INIT_LEVEL;
      for (int c = 0; c < N_CH; c++)
        cnt[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (sync_q[c] != level_r[c]) begin
          if (cnt[c] == CW'(FILTER_CYCLES - 1)) begin
            level_r[c] <= ~level_r[c];
            cnt[c]     <= '0;
          end else begin
            cnt[c] <= cnt[c] + 1'b1;
          end
        end else begin
          cnt[c] <= '0;
        end
      end
    end
  end

  assign level_out = level_r;
`else
  assign level_out = sync_q;
`endif

  // History register: previous-cycle level for edge detection
  always_ff @(posedge clk) begin
    if (rst) level_d <= INIT_LEVEL;
    else     level_d <= level_out;
  end

  assign rise_edge = level_out & ~level_d;
  assign fall_edge = ~level_out & level_d;

  // Per-channel gating of edge pulses by the runtime edge selection
  always_comb begin
    event_pulse = '0;
    for (int c = 0; c < N_CH; c++)
      event_pulse[c] = (rise_edge[c] & edge_sel[2*c])
                     | (fall_edge[c] & edge_sel[2*c+1]);
  end

  // Sticky flags: a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) flag_r <= '0;
    else     flag_r <= (flag_r & ~flag_clr) | event_pulse;
  end

  assign event_flag = flag_r;
  assign irq        = |flag_r;

endmodule

// File: tb/tb_synch_edge_detect_multi.sv
// Scoreboard bench for synch_edge_detect_multi (N_CH=4, SYNC_STAGES=2).
// Filter vectors are used when SYNCH_DETECT_FILTER_EN is defined.
module tb_synch_edge_detect_multi;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] ev;
    logic [3:0] flag;
    logic       irq;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [3:0] async_in;
  logic [7:0] edge_sel;
  logic [3:0] flag_clr;
  logic [3:0] level_out;
  logic [3:0] rise_edge;
  logic [3:0] fall_edge;
  logic [3:0] event_pulse;
  logic [3:0] event_flag;
  logic       irq;

  obs_t  exp_q [$];
  string name_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  synch_edge_detect_multi #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .FILTER_CYCLES(4),
    .INIT_LEVEL(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .async_in(async_in),
    .edge_sel(edge_sel),
    .flag_clr(flag_clr),
    .level_out(level_out),
    .rise_edge(rise_edge),
    .fall_edge(fall_edge),
    .event_pulse(event_pulse),
    .event_flag(event_flag),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each cycle's outputs with the queued expectation
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{level_out, rise_edge, fall_edge,
            event_pulse, event_flag, irq};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got lvl=%h rise=%h fall=%h ev=%h flag=%h irq=%b want lvl=%h rise=%h fall=%h ev=%h flag=%h irq=%b",
                 nm, a.lvl, a.rise, a.fall, a.ev, a.flag, a.irq,
                 e.lvl, e.rise, e.fall, e.ev, e.flag, e.irq);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected this cycle
  task automatic step(input logic r, input logic [3:0] a,
                      input logic [7:0] s, input logic [3:0] c,
                      input logic [3:0] l, input logic [3:0] ri,
                      input logic [3:0] fa, input logic [3:0] ev,
                      input logic [3:0] fl, input string nm);
    obs_t e;
    rst      = r;
    async_in = a;
    edge_sel = s;
    flag_clr = c;
    e = '{l, ri, fa, ev, fl, |fl};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    async_in = 4'hF;
    edge_sel = 8'h00;
    flag_clr = 4'h0;
    @(posedge clk);
    #1;

    step(1, 4'hF, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rst0");
    step(1, 4'hF, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rst1");
    for (int i = 0; i < 10; i++)
      step(0, 4'hF, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rst_idle");

`ifdef SYNCH_DETECT_FILTER_EN
    for (int i = 0; i < 3; i++)
      step(0, 4'h7, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "glitch_lo");
    for (int i = 0; i < 8; i++)
      step(0, 4'hF, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "glitch_idle");

    for (int i = 0; i < 4; i++)
      step(0, 4'h7, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "flt_lo");
    step(0, 4'hF, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "flt_wait0");
    step(0, 4'hF, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "flt_wait1");
    step(0, 4'hF, 8'hC0, 4'h0, 4'h7, 4'h0, 4'h8, 4'h8, 4'h0, "flt_fall");
    step(0, 4'hF, 8'hC0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'h8, "flt_flag");
    step(0, 4'hF, 8'hC0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'h8, "flt_hold0");
    step(0, 4'hF, 8'hC0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'h8, "flt_hold1");
    step(0, 4'hF, 8'hC0, 4'h0, 4'hF, 4'h8, 4'h0, 4'h8, 4'h8, "flt_rise");
    step(0, 4'hF, 8'hC0, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0, 4'h8, "flt_clr");
    step(0, 4'hF, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "flt_clrd");

    for (int i = 0; i < 4; i++)
      step(0, 4'h7, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "mf_pend");
    step(1, 4'h7, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "mf_rst");
    for (int i = 0; i < 8; i++)
      step(0, 4'hF, 8'hC0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "mf_after");
`else
    step(0, 4'hE, 8'h02, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "fall_a");
    step(0, 4'hE, 8'h02, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "fall_b");
    step(0, 4'hE, 8'h02, 4'h0, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0, "fall_pulse");
    step(0, 4'hE, 8'h02, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, "fall_flag");

    step(0, 4'hC, 8'h02, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, "sel00_a");
    step(0, 4'hC, 8'h02, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, "sel00_b");
    step(0, 4'hC, 8'h02, 4'h0, 4'hC, 4'h0, 4'h2, 4'h0, 4'h1, "sel00_fall");
    step(0, 4'hC, 8'h02, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h1, "sel00_hold");

    step(0, 4'hE, 8'h06, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h1, "sel01_a");
    step(0, 4'hE, 8'h06, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h1, "sel01_b");
    step(0, 4'hE, 8'h06, 4'h0, 4'hE, 4'h2, 4'h0, 4'h2, 4'h1, "sel01_rise");
    step(0, 4'hC, 8'h06, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h3, "sel01_flag");
    step(0, 4'hC, 8'h06, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h3, "sel01_c");
    step(0, 4'hC, 8'h06, 4'h0, 4'hC, 4'h0, 4'h2, 4'h0, 4'h3, "sel01_fall");
    step(0, 4'hC, 8'h06, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h3, "sel01_hold");

    step(0, 4'hC, 8'h06, 4'hF, 4'hC, 4'h0, 4'h0, 4'h0, 4'h3, "clr_all");
    step(0, 4'hC, 8'h06, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, "clr_done");

    step(0, 4'hE, 8'h0C, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, "sel11_a");
    step(0, 4'hE, 8'h0C, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, "sel11_b");
    step(0, 4'hE, 8'h0C, 4'h0, 4'hE, 4'h2, 4'h0, 4'h2, 4'h0, "sel11_rise");
    step(0, 4'hC, 8'h0C, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h2, "sel11_flag");
    step(0, 4'hC, 8'h0C, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h2, "sel11_c");
    step(0, 4'hC, 8'h0C, 4'h0, 4'hC, 4'h0, 4'h2, 4'h2, 4'h2, "sel11_fall");
    step(0, 4'hC, 8'h0C, 4'h2, 4'hC, 4'h0, 4'h0, 4'h0, 4'h2, "sel11_clr");
    step(0, 4'hC, 8'h0C, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, "sel11_clrd");

    step(0, 4'h8, 8'h20, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, "col_a");
    step(0, 4'h8, 8'h20, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, "col_b");
    step(0, 4'h8, 8'h20, 4'h4, 4'h8, 4'h0, 4'h4, 4'h4, 4'h0, "col_pulse");
    step(0, 4'h8, 8'h20, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h4, "col_set_wins");
    step(0, 4'h8, 8'h20, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, "col_cleared");
    step(0, 4'h8, 8'h20, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, "col_idle");

    step(0, 4'hF, 8'hFF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, "multi_a");
    step(0, 4'hF, 8'hFF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, "multi_b");
    step(0, 4'hF, 8'hFF, 4'h0, 4'hF, 4'h7, 4'h0, 4'h7, 4'h0, "multi_rise");
    step(0, 4'hF, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h7, "multi_flag");

    step(0, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h7, "mid_a");
    step(1, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h7, "mid_rst");
    step(0, 4'hF, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "mid_after");
    for (int i = 0; i < 3; i++)
      step(0, 4'hF, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "mid_quiet");

    step(1, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rel_rst");
    step(0, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rel_a");
    step(0, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "rel_b");
    step(0, 4'h0, 8'hFF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, "rel_fall");
    step(0, 4'h0, 8'hFF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, "rel_flag");
`endif

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
